// File: rtl/npc_predict_unit_pkg.sv
// Shared types and constants for the fetch-stage next-PC unit and its BTB.
package npc_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int BTB_ENTRIES_DEF = 16;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    localparam int IDX_W_DEF = idx_w(BTB_ENTRIES_DEF);
    localparam int TAG_W_DEF = XLEN_DEF - IDX_W_DEF - 2;

    // 2-bit direction counter encoding; ctr[1] is the taken prediction.
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]  target;
        logic [1:0]           ctr;
    } btb_entry_t;

endpackage

// File: rtl/npc_predict_unit_btb_table.sv
// Direct-mapped BTB: combinational lookup on the fetch PC, single training
// write port with 2-bit saturating direction counters.
module btb_table
    import npc_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_valid,
    input  logic [XLEN-1:0] wr_pc,
    input  logic            wr_taken,
    input  logic [XLEN-1:0] wr_target
);

    localparam int IDX_W = idx_w(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // The entry struct is sized from the package defaults, so the table
    // geometry must match them.
    if (XLEN != XLEN_DEF || BTB_ENTRIES != BTB_ENTRIES_DEF) begin : g_cfg_check
        $error("btb_table: geometry differs from npc_pkg entry layout");
    end

    btb_entry_t mem_q [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    logic             unused_pc_lsb;

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign rd_tag = rd_pc[XLEN-1:IDX_W+2];
    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[XLEN-1:IDX_W+2];
    assign unused_pc_lsb = ^{rd_pc[1:0], wr_pc[1:0]};

    function automatic logic [1:0] ctr_sat(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

    btb_entry_t rd_entry;
    btb_entry_t wr_cur;
    btb_entry_t wr_entry_d;
    logic       wr_en;

    always_comb begin
        rd_entry  = mem_q[rd_idx];
        rd_hit    = rd_entry.valid && (rd_entry.tag == rd_tag) && rd_entry.ctr[1];
        rd_target = rd_entry.target;
    end

    always_comb begin
        wr_cur     = mem_q[wr_idx];
        wr_entry_d = wr_cur;
        wr_en      = 1'b0;
        if (wr_valid) begin
            if (wr_cur.valid && (wr_cur.tag == wr_tag)) begin
                wr_en          = 1'b1;
                wr_entry_d.ctr = ctr_sat(wr_cur.ctr, wr_taken);
                if (wr_taken) begin
                    wr_entry_d.target = wr_target;
                end
            end else if (wr_taken) begin
                // Allocation evicts whatever aliased entry lived at this index.
                wr_en             = 1'b1;
                wr_entry_d.valid  = 1'b1;
                wr_entry_d.tag    = wr_tag;
                wr_entry_d.target = wr_target;
                wr_entry_d.ctr    = WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                mem_q[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_entry_d;
        end
    end

endmodule

// File: rtl/npc_predict_unit.sv
// Fetch PC register with redirect/stall/prediction priority mux around the BTB.
module npc_predict_unit
    import npc_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter int              BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            id_redirect,
    input  logic [XLEN-1:0] id_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            btb_hit;
    logic [XLEN-1:0] btb_target;

    btb_table #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (pc_q),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_valid  (upd_valid),
        .wr_pc     (upd_pc),
        .wr_taken  (upd_taken),
        .wr_target (upd_target)
    );

    always_comb begin
        pc_f          = pc_q;
        pred_taken_f  = btb_hit;
        pred_target_f = btb_hit ? btb_target : pc_q + XLEN'(4);
    end

    // Later pipeline stages know more, so they win over earlier ones and over stall.
    always_comb begin
        pc_d = pred_target_f;
        if (ex_redirect) begin
            pc_d = ex_target;
        end else if (id_redirect) begin
            pc_d = id_target;
        end else if (stall_f) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Randomized self-checking bench for npc_predict_unit with a behavioural BTB/PC model.
module tb_npc_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        id_redirect;
    logic [31:0] id_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    npc_predict_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall_f       (stall_f),
        .ex_redirect   (ex_redirect),
        .ex_target     (ex_target),
        .id_redirect   (id_redirect),
        .id_target     (id_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .pc_f          (pc_f),
        .pred_taken_f  (pred_taken_f),
        .pred_target_f (pred_target_f)
    );

    // Behavioural model: 16 entries, index = word address mod 16, tag = pc / 64.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_pc;

    function automatic int unsigned m_idx(input logic [31:0] pc);
        return (pc / 4) % 16;
    endfunction

    function automatic bit m_pred();
        int unsigned i = m_idx(m_pc);
        return m_valid[i] && (m_tag[i] == m_pc / 64) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target();
        if (m_pred()) return m_tgt[m_idx(m_pc)];
        return m_pc + 32'd4;
    endfunction

    task automatic model_edge();
        logic [31:0] nxt;
        int unsigned i;
        if (rst) begin
            m_pc = 32'h0;
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
            return;
        end
        if (ex_redirect)      nxt = ex_target;
        else if (id_redirect) nxt = id_target;
        else if (stall_f)     nxt = m_pc;
        else                  nxt = m_pred_target();
        if (upd_valid) begin
            i = m_idx(upd_pc);
            if (m_valid[i] && m_tag[i] == upd_pc / 64) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1;
                m_tag[i]   = upd_pc / 64;
                m_tgt[i]   = upd_target;
                m_ctr[i]   = 2;
            end
        end
        m_pc = nxt;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("pc_f", pc_f, m_pc);
        chk("pred_taken_f", {31'd0, pred_taken_f}, {31'd0, m_pred()});
        chk("pred_target_f", pred_target_f, m_pred_target());
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic step();
        compare_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        stall_f = 0; ex_redirect = 0; ex_target = 0; id_redirect = 0; id_target = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    endtask

    task automatic train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        idle(); stall_f = 1; upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        step();
    endtask

    task automatic jump(input logic [31:0] tgt);
        idle(); ex_redirect = 1; ex_target = tgt;
        step();
        idle();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] pool [6];
        pool[0] = 32'h40; pool[1] = 32'h440; pool[2] = 32'h80;
        pool[3] = 32'h3C; pool[4] = 32'hFFFF_FFFC; pool[5] = $urandom & 32'h0000_0FFC;
        if ($urandom_range(0, 15) == 0) return $urandom;
        return pool[$urandom_range(0, 5)];
    endfunction

    initial begin
        idle();
        rst = 1;
        @(posedge clk); model_edge(); #1;
        step();
        chk("reset_pc", pc_f, 32'h0);
        chk("reset_pred", {31'd0, pred_taken_f}, 32'd0);
        chk("reset_tgt", pred_target_f, 32'h4);

        // Free run from reset.
        rst = 0;
        chk("run0", pc_f, 32'h0); step();
        chk("run1", pc_f, 32'h4); step();
        chk("run2", pc_f, 32'h8); step();
        chk("run3", pc_f, 32'hC);
        chk("run_pred", {31'd0, pred_taken_f}, 32'd0);

        // Train and predict, then untrain.
        train(32'h40, 1, 32'h100);
        jump(32'h40);
        chk("trained_pred", {31'd0, pred_taken_f}, 32'd1);
        step();
        chk("trained_next", pc_f, 32'h100);
        train(32'h40, 0, 32'h0);
        train(32'h40, 0, 32'h0);
        jump(32'h40);
        chk("untrained_pred", {31'd0, pred_taken_f}, 32'd0);
        step();
        chk("untrained_next", pc_f, 32'h44);

        // Priority.
        idle(); stall_f = 1; id_redirect = 1; id_target = 32'h200; ex_redirect = 1; ex_target = 32'h300;
        step();
        chk("prio_ex", pc_f, 32'h300);
        ex_redirect = 0;
        step();
        chk("prio_id", pc_f, 32'h200);

        // Aliasing at index 0.
        train(32'h40, 1, 32'h100);
        train(32'h440, 1, 32'h800);
        jump(32'h40);
        chk("alias_miss", {31'd0, pred_taken_f}, 32'd0);
        step();
        chk("alias_miss_next", pc_f, 32'h44);
        jump(32'h440);
        step();
        chk("alias_hit_next", pc_f, 32'h800);

        // Read-before-write with ctr=1.
        train(32'h40, 1, 32'h100);
        train(32'h40, 0, 32'h0);
        jump(32'h40);
        upd_valid = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 32'h100;
        chk("rbw_pred", {31'd0, pred_taken_f}, 32'd0);
        step();
        chk("rbw_next", pc_f, 32'h44);
        jump(32'h40);
        chk("rbw_after", {31'd0, pred_taken_f}, 32'd1);

        // Wrap, then reset mid-operation.
        jump(32'hFFFF_FFFC);
        chk("wrap_tgt", pred_target_f, 32'h0);
        step();
        chk("wrap_next", pc_f, 32'h0);
        rst = 1; ex_redirect = 1; ex_target = 32'h300;
        upd_valid = 1; upd_pc = 32'h80; upd_taken = 1; upd_target = 32'h500;
        step();
        rst = 0;
        chk("midrst_pc", pc_f, 32'h0);
        jump(32'h40);
        chk("midrst_inval40", {31'd0, pred_taken_f}, 32'd0);
        jump(32'h80);
        chk("midrst_inval80", {31'd0, pred_taken_f}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 99) < 2);
            stall_f     = ($urandom_range(0, 99) < 20);
            ex_redirect = ($urandom_range(0, 99) < 10);
            ex_target   = rand_addr();
            id_redirect = ($urandom_range(0, 99) < 10);
            id_target   = rand_addr();
            upd_valid   = ($urandom_range(0, 99) < 50);
            upd_pc      = ($urandom_range(0, 1) == 1) ? m_pc : rand_addr();
            upd_taken   = ($urandom_range(0, 99) < 60);
            upd_target  = rand_addr();
            step();
        end
        rst = 0; idle();
        compare_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
